// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressable data memory with a REQ/READY/RVALID handshake and configurable read latency.
// Define DMEM_BIG_ENDIAN_EN for big-endian byte order; the default build is RISC-V little-endian.
module dmem_ctrl #(
    parameter int    ADDR_W    = 10,
    parameter int    DEPTH     = 1024,
    parameter int    READ_LAT  = 1,
    parameter string INIT_FILE = ""
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic [1:0]        SIZE,
    input  logic              UNSIGNED,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [31:0]       WDATA,
    output logic              READY,
    output logic              RVALID,
    output logic [31:0]       RDATA,
    output logic              ERR
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ready_q, ready_d, rvalid_q, rvalid_d, err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d, uns_q, uns_d;
    logic [1:0]        size_q, size_d;
    logic [7:0]        mem_q [DEPTH];

    logic              accept_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic              req_we_s, req_uns_s;
    logic [1:0]        req_size_s;
    logic [2:0]        nbytes_s;
    logic [31:0]       last_s;
    logic              err_s;
    logic [7:0]        b_s [4];
    logic [15:0]       half_s;
    logic [31:0]       word_s, load_s;

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (a < 32'(DEPTH)) begin
            return mem_q[a[ADDR_W-1:0]];
        end else begin
            return 8'h00;
        end
    endfunction

    // Memory image at time 0: zero-filled.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] = 8'h00;
    end

    assign accept_s = REQ & ready_q;

    // In IDLE the live inputs describe the access; afterwards the captured copy does.
    always_comb begin
        if (ready_q) begin
            req_addr_s = ADDR;   req_we_s  = WE;
            req_size_s = SIZE;   req_uns_s = UNSIGNED;
        end else begin
            req_addr_s = addr_q; req_we_s  = we_q;
            req_size_s = size_q; req_uns_s = uns_q;
        end
    end

    // Access width, alignment and range check (32-bit sum so ADDR+k cannot wrap).
    always_comb begin
        case (req_size_s)
            2'b00:   begin nbytes_s = 3'd1; err_s = 1'b0; end
            2'b01:   begin nbytes_s = 3'd2; err_s = req_addr_s[0]; end
            2'b10:   begin nbytes_s = 3'd4; err_s = (req_addr_s[1:0] != 2'b00); end
            default: begin nbytes_s = 3'd4; err_s = 1'b1; end
        endcase
        last_s = 32'(req_addr_s) + 32'(nbytes_s) - 32'd1;
        err_s  = err_s | (last_s >= 32'(DEPTH));
    end

    // Gather the addressed bytes and extend to 32 bits.
    always_comb begin
        for (int k = 0; k < 4; k++) b_s[k] = rd_byte(32'(req_addr_s) + 32'(k));
`ifdef DMEM_BIG_ENDIAN_EN
        half_s = {b_s[0], b_s[1]};
        word_s = {b_s[0], b_s[1], b_s[2], b_s[3]};
`else
        half_s = {b_s[1], b_s[0]};
        word_s = {b_s[3], b_s[2], b_s[1], b_s[0]};
`endif
        case (req_size_s)
            2'b00:   load_s = req_uns_s ? {24'h000000, b_s[0]} : {{24{b_s[0][7]}}, b_s[0]};
            2'b01:   load_s = req_uns_s ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            default: load_s = word_s;
        endcase
    end

    // Stores commit at the accept edge so a load accepted afterwards observes them.
    always_ff @(posedge CLK) begin
        if (!RST && accept_s && WE && !err_s) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < nbytes_s) begin
`ifdef DMEM_BIG_ENDIAN_EN
                    mem_q[ADDR + ADDR_W'(k)] <= WDATA[8*(int'(nbytes_s)-1-k) +: 8];
`else
                    mem_q[ADDR + ADDR_W'(k)] <= WDATA[8*k +: 8];
`endif
                end
            end
        end
    end

    // State, counter, captured request and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;  cnt_q   <= 4'd0;
            ready_q  <= 1'b1;    rvalid_q <= 1'b0;
            err_q    <= 1'b0;    rdata_q <= 32'h0;
            addr_q   <= '0;      we_q    <= 1'b0;
            size_q   <= 2'b00;   uns_q   <= 1'b0;
        end else begin
            state_q  <= state_d; cnt_q   <= cnt_d;
            ready_q  <= ready_d; rvalid_q <= rvalid_d;
            err_q    <= err_d;   rdata_q <= rdata_d;
            addr_q   <= addr_d;  we_q    <= we_d;
            size_q   <= size_d;  uns_q   <= uns_d;
        end
    end

    // Next state: WAIT spans READ_LAT-1 cycles so RESP completes READ_LAT cycles after accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = accept_s ? ADDR     : addr_q;
        we_d    = accept_s ? WE       : we_q;
        size_d  = accept_s ? SIZE     : size_q;
        uns_d   = accept_s ? UNSIGNED : uns_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    cnt_d   = 4'(READ_LAT - 1);
                    state_d = (READ_LAT == 1) ? S_RESP : S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? S_RESP : S_WAIT;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: the response is formed on the transition into RESP; RDATA holds otherwise.
    always_comb begin
        ready_d  = (state_d == S_IDLE);
        rvalid_d = (state_d == S_RESP);
        err_d    = rvalid_d & err_s;
        if (rvalid_d) begin
            rdata_d = (err_s || req_we_s) ? 32'h0 : load_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    assign READY  = ready_q;
    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;
    assign ERR    = err_q;

endmodule
